// File: rtl/knn_stream_ctrl.sv
// KNN stream controller: buffers reference points and streams them LANES per beat,
// together with the latched test point, into the distance datapath, then drains and flags results.
module knn_stream_ctrl #(
    parameter int DATA_W    = 32,
    parameter int NUM_PTS   = 8,
    parameter int ADDR_W    = 3,
    parameter int LANES     = 1,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [ADDR_W:0]         n_pts_i,
    input  logic [DATA_W-1:0]       test_pt_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    output logic [DATA_W-1:0]       test_pt_o,
    output logic [LANES*DATA_W-1:0] data_pt_o,
    output logic [LANES-1:0]        lane_vld_o,
    output logic                    dp_valid_o,
    input  logic                    dp_ready_i,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic                    done_o
);
    localparam int AW1 = ADDR_W + 1;
    localparam int CW1 = CNT_W + 1;
    localparam logic [ADDR_W:0] NPTS       = AW1'(NUM_PTS);
    localparam logic [CNT_W:0]  DRAIN_LAST = CW1'(DRAIN_CYC);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        STREAM = 4'b0010,
        DRAIN  = 4'b0100,
        OUTPUT = 4'b1000
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0]             mem [NUM_PTS];
    logic [DATA_W-1:0]             test_pt_q;
    logic [ADDR_W:0]               n_q, n_clamp, n_beats, ptr;
    logic [CNT_W-1:0]              cnt;
    logic [LANES-1:0][DATA_W-1:0]  beat_data;
    logic [LANES-1:0]              beat_vld;
    logic                          load, beat_last, drain_done, wr_ok;

    assign n_clamp    = (n_pts_i > NPTS) ? NPTS : n_pts_i;
    assign n_beats    = AW1'((32'(n_q) + LANES - 1) / LANES);
    // output regs may advance when empty or when the current beat is taken
    assign load       = !dp_valid_o || dp_ready_i;
    assign beat_last  = dp_valid_o && dp_ready_i && (ptr == n_beats);
    assign drain_done = ({1'b0, cnt} + 1'b1) >= DRAIN_LAST;
    assign wr_ok      = wr_en_i && (state == IDLE || state == OUTPUT) && ({1'b0, wr_addr_i} < NPTS);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [ADDR_W:0] idx;
        assign idx          = AW1'(32'(ptr) * LANES + j);
        assign beat_vld[j]  = idx < n_q;
        assign beat_data[j] = beat_vld[j] ? mem[idx[ADDR_W-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start_i) state_n = (n_clamp == '0) ? DRAIN : STREAM;
            STREAM:  if (!start_i) state_n = IDLE;
                     else if (beat_last) state_n = DRAIN;
            DRAIN:   if (!start_i) state_n = IDLE;
                     else if (drain_done) state_n = OUTPUT;
            OUTPUT:  if (!start_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PTS; i++) mem[i] <= '0;
            test_pt_q  <= '0;
            n_q        <= '0;
            ptr        <= '0;
            cnt        <= '0;
            test_pt_o  <= '0;
            data_pt_o  <= '0;
            lane_vld_o <= '0;
            dp_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            if (wr_ok) mem[wr_addr_i] <= wr_data_i;
            if (state == IDLE && start_i) begin
                test_pt_q <= test_pt_i;
                n_q       <= n_clamp;
            end
            if (state != STREAM)
                ptr <= '0;
            else if (start_i && load && ptr < n_beats)
                ptr <= ptr + 1'b1;
            cnt <= (state == DRAIN) ? cnt + 1'b1 : '0;

            // beat registers: hold while stalled, clear on last transfer or abort
            if (state == STREAM && start_i) begin
                if (load) begin
                    if (ptr < n_beats) begin
                        dp_valid_o <= 1'b1;
                        data_pt_o  <= beat_data;
                        lane_vld_o <= beat_vld;
                        test_pt_o  <= test_pt_q;
                    end else begin
                        dp_valid_o <= 1'b0;
                        data_pt_o  <= '0;
                        lane_vld_o <= '0;
                        test_pt_o  <= '0;
                    end
                end
            end else begin
                dp_valid_o <= 1'b0;
                data_pt_o  <= '0;
                lane_vld_o <= '0;
                test_pt_o  <= '0;
            end

            busy_o  <= (state_n == STREAM) || (state_n == DRAIN);
            valid_o <= (state_n == OUTPUT);
            done_o  <= (state_n == OUTPUT) && (state != OUTPUT);
        end
    end

endmodule

// File: tb/tb_knn_stream_ctrl.sv
// Directed bench for knn_stream_ctrl: a LANES=1 instance and a LANES=4 instance share stimulus.
module tb_knn_stream_ctrl;
    logic         clk, rst, start, wr_en, dp_ready;
    logic [3:0]   n_pts;
    logic [31:0]  test_pt, wr_data;
    logic [2:0]   wr_addr;

    logic [31:0]  a_tp, a_data;
    logic [0:0]   a_lv;
    logic         a_dv, a_busy, a_valid, a_done;
    logic [31:0]  b_tp;
    logic [127:0] b_data;
    logic [3:0]   b_lv;
    logic         b_dv, b_busy, b_valid, b_done;

    int checks = 0;
    int errors = 0;

    logic [31:0]  got[$];
    logic [127:0] gotb[$];
    logic [3:0]   gotbm[$];
    int pres, hold12, tp_bad, nd_a, fd_a, nd_b, fd_b;
    logic dv_h[64], busy_h[64], val_h[64], any_h[64];

    knn_stream_ctrl dut_a (
        .clk(clk), .rst(rst), .start_i(start), .n_pts_i(n_pts), .test_pt_i(test_pt),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .test_pt_o(a_tp), .data_pt_o(a_data), .lane_vld_o(a_lv), .dp_valid_o(a_dv),
        .dp_ready_i(dp_ready), .busy_o(a_busy), .valid_o(a_valid), .done_o(a_done)
    );

    knn_stream_ctrl #(.LANES(4)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .n_pts_i(n_pts), .test_pt_i(test_pt),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .test_pt_o(b_tp), .data_pt_o(b_data), .lane_vld_o(b_lv), .dp_valid_o(b_dv),
        .dp_ready_i(dp_ready), .busy_o(b_busy), .valid_o(b_valid), .done_o(b_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1; wr_addr = 3'(a); wr_data = d;
        tick;
        wr_en = 0;
    endtask

    // cycle c = outputs seen after edge c; the start edge is edge 0; fixed 30-cycle window
    task automatic run_job(input int n, input logic [31:0] tp, input int st_lo, input int st_hi,
                           input int abort_at, input int wr_at, input int wr_a,
                           input logic [31:0] wr_d, input int rst_at);
        got.delete(); gotb.delete(); gotbm.delete();
        pres = 0; hold12 = 0; tp_bad = 0; nd_a = 0; fd_a = -1; nd_b = 0; fd_b = -1;
        n_pts = 4'(n); test_pt = tp; dp_ready = 1; start = 1;
        for (int c = 0; c < 30; c++) begin
            tick;
            dp_ready = !(c >= st_lo && c <= st_hi);
            if (c == abort_at) start = 0;
            rst = (c == rst_at);
            wr_en = (c == wr_at); wr_addr = 3'(wr_a); wr_data = wr_d;
            dv_h[c] = a_dv; busy_h[c] = a_busy; val_h[c] = a_valid;
            any_h[c] = |{a_tp, a_data, a_lv, a_dv, a_busy, a_valid, a_done};
            if (a_dv) begin
                pres++;
                if (a_data == 32'd12) hold12++;
                if (a_tp !== tp) tp_bad++;
                if (dp_ready) got.push_back(a_data);
            end
            if (b_dv && dp_ready) begin gotb.push_back(b_data); gotbm.push_back(b_lv); end
            if (a_done) begin nd_a++; if (fd_a < 0) fd_a = c; end
            if (b_done) begin nd_b++; if (fd_b < 0) fd_b = c; end
        end
        rst = 0; wr_en = 0;
    endtask

    task automatic test_reset;
        rst = 1; start = 0; wr_en = 0; wr_addr = 0; wr_data = 0; n_pts = 0; test_pt = 0; dp_ready = 1;
        tick; tick;
        rst = 0;
        tick;
        checks++; if ({a_tp, a_data, a_lv, a_dv, a_busy, a_valid, a_done} !== '0) begin errors++; $display("FAIL reset_a outputs got %h want 0", {a_tp, a_data, a_lv, a_dv, a_busy, a_valid, a_done}); end
        checks++; if ({b_tp, b_data, b_lv, b_dv, b_busy, b_valid, b_done} !== '0) begin errors++; $display("FAIL reset_b outputs got %h want 0", {b_tp, b_data, b_lv, b_dv, b_busy, b_valid, b_done}); end
        for (int i = 0; i < 8; i++) wr(i, 32'(10 + i));
    endtask

    task automatic test_defaults;
        run_job(8, 32'd5, -1, -1, -1, -1, 0, 0, -1);
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL t1_nbeats got %0d want 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'(10 + i)) begin errors++; $display("FAIL t1_beat%0d got %0d want %0d", i, got[i], 10 + i); end
        end
        checks++; if (pres !== 8) begin errors++; $display("FAIL t1_present got %0d want 8", pres); end
        checks++; if (tp_bad !== 0) begin errors++; $display("FAIL t1_test_pt bad beats %0d want 0", tp_bad); end
        checks++; if ({dv_h[0], dv_h[1], dv_h[8], dv_h[9]} !== 4'b0110) begin errors++; $display("FAIL t1_dv_timing got %b want 0110", {dv_h[0], dv_h[1], dv_h[8], dv_h[9]}); end
        checks++; if ({busy_h[0], busy_h[10], busy_h[11]} !== 3'b110) begin errors++; $display("FAIL t1_busy got %b want 110", {busy_h[0], busy_h[10], busy_h[11]}); end
        checks++; if (fd_a !== 11 || nd_a !== 1) begin errors++; $display("FAIL t1_done cyc %0d cnt %0d want 11/1", fd_a, nd_a); end
        checks++; if ({val_h[10], val_h[11], val_h[29]} !== 3'b011) begin errors++; $display("FAIL t1_valid got %b want 011", {val_h[10], val_h[11], val_h[29]}); end
        start = 0;
        tick;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop got %b want 0", a_valid); end
    endtask

    task automatic test_backpressure;
        run_job(8, 32'd5, 3, 5, -1, -1, 0, 0, -1);
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL t2_nbeats got %0d want 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'(10 + i)) begin errors++; $display("FAIL t2_beat%0d got %0d want %0d", i, got[i], 10 + i); end
        end
        checks++; if (pres !== 11) begin errors++; $display("FAIL t2_present got %0d want 11", pres); end
        checks++; if (hold12 !== 4) begin errors++; $display("FAIL t2_hold12 got %0d want 4", hold12); end
        checks++; if (fd_a !== 14 || nd_a !== 1) begin errors++; $display("FAIL t2_done cyc %0d cnt %0d want 14/1", fd_a, nd_a); end
        start = 0;
        tick;
    endtask

    task automatic test_lanes4;
        run_job(6, 32'd7, -1, -1, -1, -1, 0, 0, -1);
        checks++; if (gotb.size() !== 2) begin errors++; $display("FAIL t3_nbeats got %0d want 2", gotb.size()); end
        if (gotb.size() == 2) begin
            checks++; if (gotb[0] !== {32'd13, 32'd12, 32'd11, 32'd10}) begin errors++; $display("FAIL t3_beat0 got %h", gotb[0]); end
            checks++; if (gotbm[0] !== 4'b1111) begin errors++; $display("FAIL t3_mask0 got %b want 1111", gotbm[0]); end
            checks++; if (gotb[1] !== {32'd0, 32'd0, 32'd15, 32'd14}) begin errors++; $display("FAIL t3_beat1 got %h", gotb[1]); end
            checks++; if (gotbm[1] !== 4'b0011) begin errors++; $display("FAIL t3_mask1 got %b want 0011", gotbm[1]); end
        end
        checks++; if (fd_b !== 5 || nd_b !== 1) begin errors++; $display("FAIL t3_done_b cyc %0d cnt %0d want 5/1", fd_b, nd_b); end
        checks++; if (fd_a !== 9) begin errors++; $display("FAIL t3_done_a cyc %0d want 9", fd_a); end
        start = 0;
        tick;
    endtask

    task automatic test_npts_edge;
        run_job(0, 32'd5, -1, -1, -1, -1, 0, 0, -1);
        checks++; if (pres !== 0) begin errors++; $display("FAIL t4_zero_present got %0d want 0", pres); end
        checks++; if (busy_h[0] !== 1'b1) begin errors++; $display("FAIL t4_zero_busy got %b want 1", busy_h[0]); end
        checks++; if (fd_a !== 2 || nd_a !== 1) begin errors++; $display("FAIL t4_zero_done cyc %0d cnt %0d want 2/1", fd_a, nd_a); end
        start = 0;
        tick;
        run_job(12, 32'd5, -1, -1, -1, -1, 0, 0, -1);
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL t4_clamp_nbeats got %0d want 8", got.size()); end
        checks++; if (gotb.size() !== 2) begin errors++; $display("FAIL t4_clamp_nbeats_b got %0d want 2", gotb.size()); end
        checks++; if (fd_a !== 11) begin errors++; $display("FAIL t4_clamp_done cyc %0d want 11", fd_a); end
        start = 0;
        tick;
    endtask

    task automatic test_abort;
        run_job(8, 32'd5, -1, -1, 4, -1, 0, 0, -1);
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL t5_nbeats got %0d want 4", got.size()); end
        checks++; if (dv_h[4] !== 1'b1) begin errors++; $display("FAIL t5_dv_before got %b want 1", dv_h[4]); end
        checks++; if (any_h[5] !== 1'b0) begin errors++; $display("FAIL t5_outputs_after got %b want 0", any_h[5]); end
        checks++; if (nd_a !== 0) begin errors++; $display("FAIL t5_no_done got %0d want 0", nd_a); end
        run_job(8, 32'd5, -1, -1, -1, -1, 0, 0, -1);
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL t5_restart_nbeats got %0d want 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'(10 + i)) begin errors++; $display("FAIL t5_restart_beat%0d got %0d want %0d", i, got[i], 10 + i); end
        end
        start = 0;
        tick;
    endtask

    task automatic test_write_drop;
        run_job(8, 32'd5, -1, -1, -1, 3, 2, 32'd99, -1);
        start = 0;
        tick;
        run_job(8, 32'd5, -1, -1, -1, -1, 0, 0, -1);
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL t6_nbeats got %0d want 8", got.size()); end
        if (got.size() > 2) begin
            checks++; if (got[2] !== 32'd12) begin errors++; $display("FAIL t6_point2 got %0d want 12", got[2]); end
        end
        start = 0;
        tick;
    endtask

    // rst in DRAIN with start still high: IDLE, then the job relaunches over a cleared buffer
    task automatic test_rst_mid_drain;
        run_job(8, 32'd5, -1, -1, -1, -1, 0, 0, 9);
        checks++; if (busy_h[9] !== 1'b1) begin errors++; $display("FAIL t6_busy_drain got %b want 1", busy_h[9]); end
        checks++; if (any_h[10] !== 1'b0) begin errors++; $display("FAIL t6_rst_outputs got %b want 0", any_h[10]); end
        checks++; if (got.size() !== 16) begin errors++; $display("FAIL t6_rst_nbeats got %0d want 16", got.size()); end
        for (int i = 8; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'd0) begin errors++; $display("FAIL t6_cleared%0d got %0d want 0", i - 8, got[i]); end
        end
        checks++; if (fd_a !== 22 || nd_a !== 1) begin errors++; $display("FAIL t6_relaunch_done cyc %0d cnt %0d want 22/1", fd_a, nd_a); end
        start = 0;
        tick;
    endtask

    initial begin
        test_reset;
        test_defaults;
        test_backpressure;
        test_lanes4;
        test_npts_edge;
        test_abort;
        test_write_drop;
        test_rst_mid_drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
